exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
Execute stage of the 5-stage ARM-subset pipeline. It consumes the registered outputs of the ID/EX pipeline register and computes the ALU result, the memory address for LDR/STR, and the branch target. It owns the architectural NZCV status register, which is written one cycle after an S-flagged instruction and fed back to the ID stage for condition checks. Its outputs feed the EX/MEM pipeline register and the IF stage (branch target).

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
SR_RST_VAL, 4'b0000, status register value after reset, ordered {N,Z,C,V}.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
WB_EN_In  in  1  write-back enable
MEM_R_EN_In  in  1  load
MEM_W_EN_In  in  1  store
B_In  in  1  branch instruction
S_In  in  1  update status register
EXE_CMD_In  in  4  ALU opcode
PC_In  in  32  PC+4 of the instruction
Val_Rn_In  in  32  first operand
Val_Rm_In  in  32  second register operand / store data
imm_In  in  1  immediate operand select
Shift_operand_In  in  12  shifter operand field
Signed_imm_24_In  in  24  branch offset in words
Dest_In  in  4  destination register
SR_In  in  4  status captured with the instruction {N,Z,C,V}
WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out  out  1 each  combinational pass-through
ALU_Res  out  32  ALU result / memory address
Val_Rm_Out  out  32  pass-through of Val_Rm_In (store data)
Dest_Out  out  4  pass-through
Br_taken  out  1  equals B_In
Br_Addr  out  32  branch target
SR_Out  out  4  registered status {N,Z,C,V}

Behaviour:
- The only state is the 4-bit SR. Every other output is combinational from the inputs.
- SR: at the CLK rising edge, if RST then SR = SR_RST_VAL. Otherwise, if S_In=1 and the opcode is supported, SR = {N,Z,C,V} of the current op. Otherwise SR holds. RST has priority over S_In.
- A flushed ID/EX register delivers S_In=0, so a bubble never writes SR.
- SR_Out has 1-cycle latency: an S-op in cycle t is visible on SR_Out from cycle t+1.
- Carry-in for ADC/SBC comes from SR_In[1], not SR_Out.
- Val2 selection:
  - If imm_In=1: Val2 = {24'b0, Shift_operand_In[7:0]} rotated right by 2*Shift_operand_In[11:8].
  - Else if MEM_R_EN_In or MEM_W_EN_In: Val2 = zero-extended Shift_operand_In[11:0].
  - Else: Val2 = Val_Rm_In shifted by Shift_operand_In[11:7] with type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes Val_Rm_In unchanged for every type.
- EXE_CMD encodings:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: Rn+Val2 (also used for LDR/STR)
  - 0011 ADC: Rn+Val2+C
  - 0100 SUB/CMP: Rn-Val2
  - 0101 SBC: Rn-Val2-(1-C)
  - 0110 AND/TST: Rn&Val2
  - 0111 ORR: Rn|Val2
  - 1000 EOR: Rn^Val2
  - Any other code: ALU_Res=0 and SR never written.
- Flags, computed with 33-bit arithmetic:
  - N = res[31]; Z = (res==0).
  - ADD/ADC: C = bit 32 of the sum; V = (Rn[31]==Val2[31]) & (res[31]!=Rn[31]).
  - SUB/SBC: C = NOT borrow; V = (Rn[31]!=Val2[31]) & (res[31]!=Rn[31]).
  - MOV/MVN/AND/ORR/EOR: C and V keep the current SR value.
- Br_Addr = PC_In + (sign-extended Signed_imm_24_In << 2), modulo 2^32. It is computed regardless of B_In.
- All adds and subtracts wrap modulo 2^32; there is no saturation.
- Reset asserted mid-stream clears only SR. The combinational outputs keep following the inputs.

Test Plan:
1. RST=1 for one edge, then idle ops with S_In=0 -> SR_Out=0000 throughout.
2. ADD with S_In=1, Rn=0x7FFFFFFF, imm_In=1, Shift_operand=0x001 -> ALU_Res=0x80000000; next cycle SR_Out=1001. Then ADC with SR_In=0010, Rn=1, immediate 1 -> ALU_Res=3.
3. CMP (0100) with S_In=1, Rn=Rm=5, register operand, Shift_operand=0x000 -> ALU_Res=0; SR_Out=0110 one cycle later. Same op with S_In=0 -> SR unchanged.
4. MOV with imm_In=1, Shift_operand=0x4FF -> ALU_Res=0xFF000000. MOV with register operand, Val_Rm=0x80000000, Shift_operand=0x240 (ASR #4) -> 0xF8000000.
5. LDR with MEM_R_EN=1, EXE_CMD=0010, Rn=0x400, Shift_operand=0x00C, imm_In=0 -> ALU_Res=0x40C, with Val_Rm_Out, Dest_Out and the enables passed through.
6. B_In=1, PC_In=0x100, imm24=0xFFFFFE -> Br_taken=1, Br_Addr=0xF8. S_In=1 and RST=1 on the same edge -> SR_Out=0000.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM-subset pipeline.
// Computes the ALU result / memory address, the branch target, and owns the
// architectural NZCV status register. Everything except the status register
// is combinational from the ID/EX pipeline register outputs.
module exe_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter logic [3:0]  SR_RST_VAL = 4'b0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WB_EN_In,
    input  logic              MEM_R_EN_In,
    input  logic              MEM_W_EN_In,
    input  logic              B_In,
    input  logic              S_In,
    input  logic [3:0]        EXE_CMD_In,
    input  logic [DATA_W-1:0] PC_In,
    input  logic [DATA_W-1:0] Val_Rn_In,
    input  logic [DATA_W-1:0] Val_Rm_In,
    input  logic              imm_In,
    input  logic [11:0]       Shift_operand_In,
    input  logic [23:0]       Signed_imm_24_In,
    input  logic [3:0]        Dest_In,
    input  logic [3:0]        SR_In,
    output logic              WB_EN_Out,
    output logic              MEM_R_EN_Out,
    output logic              MEM_W_EN_Out,
    output logic [DATA_W-1:0] ALU_Res,
    output logic [DATA_W-1:0] Val_Rm_Out,
    output logic [3:0]        Dest_Out,
    output logic              Br_taken,
    output logic [DATA_W-1:0] Br_Addr,
    output logic [3:0]        SR_Out
);

    // ALU opcodes
    localparam logic [3:0] CmdMov = 4'b0001;
    localparam logic [3:0] CmdAdd = 4'b0010;
    localparam logic [3:0] CmdAdc = 4'b0011;
    localparam logic [3:0] CmdSub = 4'b0100;
    localparam logic [3:0] CmdSbc = 4'b0101;
    localparam logic [3:0] CmdAnd = 4'b0110;
    localparam logic [3:0] CmdOrr = 4'b0111;
    localparam logic [3:0] CmdEor = 4'b1000;
    localparam logic [3:0] CmdMvn = 4'b1001;

    // Shift types for the register operand
    localparam logic [1:0] ShLsl = 2'b00;
    localparam logic [1:0] ShLsr = 2'b01;
    localparam logic [1:0] ShAsr = 2'b10;
    localparam logic [1:0] ShRor = 2'b11;

    // Status register
    logic [3:0] sr_q;
    logic [3:0] sr_d;

    // Operand 2 path
    logic [DATA_W-1:0] imm_ext;
    logic [4:0]        imm_rot;
    logic [4:0]        sh_amt;
    logic [1:0]        sh_type;
    logic [DATA_W-1:0] val2;

    // ALU path
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] res;
    logic              flag_n;
    logic              flag_z;
    logic              flag_c;
    logic              flag_v;
    logic              cmd_ok;
    logic              carry_in;

    // Only the carry bit of the captured status is consumed here.
    logic unused_sr_in;
    assign unused_sr_in = ^{SR_In[3:2], SR_In[0]};

    // Rotate right; a zero amount returns the input unchanged since the left
    // shift by the full width yields zero.
    function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x,
                                              input logic [4:0]        r);
        ror = (x >> r) | (x << (7'(DATA_W) - 7'(r)));
    endfunction

    assign carry_in = SR_In[1];
    assign imm_ext  = {{(DATA_W-8){1'b0}}, Shift_operand_In[7:0]};
    assign imm_rot  = {Shift_operand_In[11:8], 1'b0};
    assign sh_amt   = Shift_operand_In[11:7];
    assign sh_type  = Shift_operand_In[6:5];

    // Second operand select: rotated immediate, memory offset, or shifted Rm
    always_comb begin
        val2 = Val_Rm_In;
        if (imm_In) begin
            val2 = ror(imm_ext, imm_rot);
        end else if (MEM_R_EN_In || MEM_W_EN_In) begin
            val2 = {{(DATA_W-12){1'b0}}, Shift_operand_In};
        end else begin
            case (sh_type)
                ShLsl:   val2 = Val_Rm_In << sh_amt;
                ShLsr:   val2 = Val_Rm_In >> sh_amt;
                ShAsr:   val2 = $unsigned($signed(Val_Rm_In) >>> sh_amt);
                ShRor:   val2 = ror(Val_Rm_In, sh_amt);
                default: val2 = Val_Rm_In;
            endcase
        end
    end

    // ALU and flag generation; logical ops leave C and V at the current SR value
    always_comb begin
        sum    = '0;
        res    = '0;
        flag_c = sr_q[1];
        flag_v = sr_q[0];
        cmd_ok = 1'b1;
        case (EXE_CMD_In)
            CmdMov: res = val2;
            CmdMvn: res = ~val2;
            CmdAdd, CmdAdc: begin
                sum    = {1'b0, Val_Rn_In} + {1'b0, val2}
                       + {{DATA_W{1'b0}}, (EXE_CMD_In == CmdAdc) & carry_in};
                res    = sum[DATA_W-1:0];
                flag_c = sum[DATA_W];
                flag_v = (Val_Rn_In[DATA_W-1] == val2[DATA_W-1])
                       & (res[DATA_W-1] != Val_Rn_In[DATA_W-1]);
            end
            CmdSub, CmdSbc: begin
                // Bit DATA_W of the 33-bit difference is the borrow
                sum    = {1'b0, Val_Rn_In} - {1'b0, val2}
                       - {{DATA_W{1'b0}}, (EXE_CMD_In == CmdSbc) & ~carry_in};
                res    = sum[DATA_W-1:0];
                flag_c = ~sum[DATA_W];
                flag_v = (Val_Rn_In[DATA_W-1] != val2[DATA_W-1])
                       & (res[DATA_W-1] != Val_Rn_In[DATA_W-1]);
            end
            CmdAnd: res = Val_Rn_In & val2;
            CmdOrr: res = Val_Rn_In | val2;
            CmdEor: res = Val_Rn_In ^ val2;
            default: begin
                res    = '0;
                cmd_ok = 1'b0;
            end
        endcase
        flag_n = res[DATA_W-1];
        flag_z = (res == '0);
    end

    // Next status: only a valid S-flagged op updates it (bubbles carry S_In=0)
    always_comb begin
        sr_d = sr_q;
        if (S_In && cmd_ok) begin
            sr_d = {flag_n, flag_z, flag_c, flag_v};
        end
    end

    // Status register with synchronous reset taking priority over updates
    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_q <= SR_RST_VAL;
        end else begin
            sr_q <= sr_d;
        end
    end

    // Pass-throughs and branch target
    always_comb begin
        WB_EN_Out    = WB_EN_In;
        MEM_R_EN_Out = MEM_R_EN_In;
        MEM_W_EN_Out = MEM_W_EN_In;
        Val_Rm_Out   = Val_Rm_In;
        Dest_Out     = Dest_In;
        Br_taken     = B_In;
        ALU_Res      = res;
        Br_Addr      = PC_In + {{(DATA_W-26){Signed_imm_24_In[23]}}, Signed_imm_24_In, 2'b00};
        SR_Out       = sr_q;
    end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: table of hand-derived vectors pushed
// through a scoreboard queue, plus short sequences for reset and bubbles.
module tb_exe_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, imm_In;
    logic [3:0]  EXE_CMD_In, Dest_In, SR_In;
    logic [31:0] PC_In, Val_Rn_In, Val_Rm_In;
    logic [11:0] Shift_operand_In;
    logic [23:0] Signed_imm_24_In;
    logic        WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, Br_taken;
    logic [31:0] ALU_Res, Val_Rm_Out, Br_Addr;
    logic [3:0]  Dest_Out, SR_Out;

    int tests = 0;
    int fails = 0;
    logic [3:0] sr_model = 4'b0000;

    exe_stage #(.DATA_W(32), .SR_RST_VAL(4'b0000)) dut (
        .CLK(CLK), .RST(RST),
        .WB_EN_In(WB_EN_In), .MEM_R_EN_In(MEM_R_EN_In), .MEM_W_EN_In(MEM_W_EN_In),
        .B_In(B_In), .S_In(S_In), .EXE_CMD_In(EXE_CMD_In), .PC_In(PC_In),
        .Val_Rn_In(Val_Rn_In), .Val_Rm_In(Val_Rm_In), .imm_In(imm_In),
        .Shift_operand_In(Shift_operand_In), .Signed_imm_24_In(Signed_imm_24_In),
        .Dest_In(Dest_In), .SR_In(SR_In),
        .WB_EN_Out(WB_EN_Out), .MEM_R_EN_Out(MEM_R_EN_Out), .MEM_W_EN_Out(MEM_W_EN_Out),
        .ALU_Res(ALU_Res), .Val_Rm_Out(Val_Rm_Out), .Dest_Out(Dest_Out),
        .Br_taken(Br_taken), .Br_Addr(Br_Addr), .SR_Out(SR_Out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        rst, s, imm, wb, mr, mw, b;
        logic [3:0]  cmd, dest, sr_in;
        logic [31:0] rn, rm, pc;
        logic [11:0] so;
        logic [23:0] off;
        logic [31:0] exp_res, exp_br;
        logic [3:0]  exp_sr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic rst, input logic s,
                           input logic [3:0] cmd, input logic imm, input logic wb,
                           input logic mr, input logic mw, input logic b,
                           input logic [3:0] dest, input logic [31:0] rn,
                           input logic [31:0] rm, input logic [31:0] pc,
                           input logic [11:0] so, input logic [23:0] off,
                           input logic [3:0] sr_in, input logic [31:0] exp_res,
                           input logic [31:0] exp_br, input logic [3:0] exp_sr);
        vec_t v;
        v.name = name; v.rst = rst; v.s = s; v.cmd = cmd; v.imm = imm; v.wb = wb;
        v.mr = mr; v.mw = mw; v.b = b; v.dest = dest; v.rn = rn; v.rm = rm;
        v.pc = pc; v.so = so; v.off = off; v.sr_in = sr_in;
        v.exp_res = exp_res; v.exp_br = exp_br; v.exp_sr = exp_sr;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        RST = v.rst; S_In = v.s; EXE_CMD_In = v.cmd; imm_In = v.imm;
        WB_EN_In = v.wb; MEM_R_EN_In = v.mr; MEM_W_EN_In = v.mw; B_In = v.b;
        Dest_In = v.dest; Val_Rn_In = v.rn; Val_Rm_In = v.rm; PC_In = v.pc;
        Shift_operand_In = v.so; Signed_imm_24_In = v.off; SR_In = v.sr_in;
    endtask

    initial begin
        vec_t v;
        vec_t e;
        //       name          rst s  cmd   imm wb mr mw b  dest  rn            rm
        //       pc            so      off        sr_in  exp_res       exp_br        exp_sr
        add_vec("reset",       1, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,
                32'h0,         12'h000, 24'h0,     4'h0, 32'h0,        32'h0,        4'b0000);
        add_vec("idle",        0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,
                32'h0,         12'h000, 24'h0,     4'h0, 32'h0,        32'h0,        4'b0000);
        add_vec("add_ovf",     0, 1, 4'h2, 1, 1, 0, 0, 0, 4'h1, 32'h7FFFFFFF, 32'h0,
                32'h0,         12'h001, 24'h0,     4'h0, 32'h80000000, 32'h0,        4'b1001);
        add_vec("adc_cin",     0, 0, 4'h3, 1, 1, 0, 0, 0, 4'h2, 32'h1,        32'h0,
                32'h0,         12'h001, 24'h0,     4'h2, 32'h3,        32'h0,        4'b1001);
        add_vec("cmp_eq",      0, 1, 4'h4, 0, 0, 0, 0, 0, 4'h0, 32'h5,        32'h5,
                32'h0,         12'h000, 24'h0,     4'h0, 32'h0,        32'h0,        4'b0110);
        add_vec("cmp_nos",     0, 0, 4'h4, 0, 0, 0, 0, 0, 4'h0, 32'h5,        32'h3,
                32'h0,         12'h000, 24'h0,     4'h0, 32'h2,        32'h0,        4'b0110);
        add_vec("mov_imm",     0, 1, 4'h1, 1, 1, 0, 0, 0, 4'h3, 32'h0,        32'h0,
                32'h0,         12'h4FF, 24'h0,     4'h0, 32'hFF000000, 32'h0,        4'b1010);
        add_vec("mov_asr",     0, 0, 4'h1, 0, 1, 0, 0, 0, 4'h3, 32'h0,        32'h80000000,
                32'h0,         12'h240, 24'h0,     4'h0, 32'hF8000000, 32'h0,        4'b1010);
        add_vec("ldr",         0, 0, 4'h2, 0, 1, 1, 0, 0, 4'h7, 32'h400,      32'hDEADBEEF,
                32'h0,         12'h00C, 24'h0,     4'h0, 32'h40C,      32'h0,        4'b1010);
        add_vec("branch",      0, 0, 4'h0, 0, 0, 0, 0, 1, 4'h0, 32'h0,        32'h0,
                32'h100,       12'h000, 24'hFFFFFE, 4'h0, 32'h0,       32'hF8,       4'b1010);
        add_vec("rst_s",       1, 1, 4'h2, 1, 0, 0, 0, 0, 4'h0, 32'h1,        32'h0,
                32'h0,         12'h001, 24'h0,     4'h0, 32'h2,        32'h0,        4'b0000);
        add_vec("sub_borrow",  0, 1, 4'h4, 1, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,
                32'h0,         12'h001, 24'h0,     4'h0, 32'hFFFFFFFF, 32'h0,        4'b1000);
        add_vec("sbc",         0, 1, 4'h5, 1, 0, 0, 0, 0, 4'h0, 32'h10,       32'h0,
                32'h0,         12'h005, 24'h0,     4'h0, 32'hA,        32'h0,        4'b0010);
        add_vec("adc_carry",   0, 1, 4'h3, 1, 0, 0, 0, 0, 4'h0, 32'hFFFFFFFF, 32'h0,
                32'h0,         12'h000, 24'h0,     4'h2, 32'h0,        32'h0,        4'b0110);
        add_vec("and",         0, 1, 4'h6, 0, 0, 0, 0, 0, 4'h0, 32'hF0F0F0F0, 32'hFF00FF00,
                32'h0,         12'h000, 24'h0,     4'h0, 32'hF000F000, 32'h0,        4'b1010);
        add_vec("orr_lsl",     0, 0, 4'h7, 0, 0, 0, 0, 0, 4'h0, 32'h1,        32'h1,
                32'h0,         12'h200, 24'h0,     4'h0, 32'h11,       32'h0,        4'b1010);
        add_vec("eor_lsr31",   0, 0, 4'h8, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h80000000,
                32'h0,         12'hFA0, 24'h0,     4'h0, 32'h1,        32'h0,        4'b1010);
        add_vec("mvn_ror",     0, 1, 4'h9, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'hF,
                32'h0,         12'h260, 24'h0,     4'h0, 32'h0FFFFFFF, 32'h0,        4'b0010);
        add_vec("bad_op",      0, 1, 4'hF, 0, 0, 0, 0, 0, 4'h0, 32'h5,        32'h0,
                32'h0,         12'h000, 24'h0,     4'h0, 32'h0,        32'h0,        4'b0010);
        add_vec("asr_zero",    0, 0, 4'h1, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h80000000,
                32'h0,         12'h040, 24'h0,     4'h0, 32'h80000000, 32'h0,        4'b0010);
        add_vec("br_fwd",      0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,
                32'h1000,      12'h000, 24'h10,    4'h0, 32'h0,        32'h1040,     4'b0010);
        add_vec("str",         0, 0, 4'h2, 0, 0, 0, 1, 0, 4'h3, 32'h800,      32'h12345678,
                32'h0,         12'hFFF, 24'h0,     4'h0, 32'h17FF,     32'h0,        4'b0010);

        drive(vecs[0]);
        @(posedge CLK);
        #1;
        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v);
            sb_q.push_back(v);
            @(negedge CLK);
            e = sb_q.pop_front();
            check({e.name, ".res"},  ALU_Res, e.exp_res);
            check({e.name, ".br"},   Br_Addr, e.exp_br);
            check({e.name, ".pass"},
                  {WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, Br_taken, Dest_Out},
                  {e.wb, e.mr, e.mw, e.b, e.dest});
            check({e.name, ".rm"},   Val_Rm_Out, e.rm);
            // Status must not change before the edge that samples this op
            check({e.name, ".sr_pre"}, {28'h0, SR_Out}, {28'h0, sr_model});
            @(posedge CLK);
            #1;
            sr_model = e.exp_sr;
            check({e.name, ".sr"}, {28'h0, SR_Out}, {28'h0, e.exp_sr});
        end

        // Reset held across two edges while an S-op is presented, then released
        RST = 1'b1; S_In = 1'b1; EXE_CMD_In = 4'h2; imm_In = 1'b1;
        MEM_R_EN_In = 1'b0; MEM_W_EN_In = 1'b0; B_In = 1'b0;
        Val_Rn_In = 32'h7FFFFFFF; Shift_operand_In = 12'h001; SR_In = 4'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            check("seq_rst.res", ALU_Res, 32'h80000000);
            @(posedge CLK);
            #1;
            check("seq_rst.sr", {28'h0, SR_Out}, 32'h0);
        end
        RST = 1'b0;
        @(negedge CLK);
        check("seq_rel.sr_pre", {28'h0, SR_Out}, 32'h0);
        @(posedge CLK);
        #1;
        check("seq_rel.sr", {28'h0, SR_Out}, 32'h9);

        // Bubbles (S_In=0) whose op would produce different flags never write SR
        S_In = 1'b0; EXE_CMD_In = 4'h4; Val_Rn_In = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            check("seq_bubble.sr", {28'h0, SR_Out}, 32'h9);
        end
        // Same op with S_In=1 does write it
        S_In = 1'b1;
        @(posedge CLK);
        #1;
        check("seq_sub.sr", {28'h0, SR_Out}, 32'h8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
